// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the programmable synchronous FIFO.
package fifo_pkg;
  localparam int FWFT_OFF      = 0;
  localparam int FWFT_ON       = 1;
  // Default almost-full threshold sits this many entries below SIZE.
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_TH     = 2;

  // Occupancy counter must represent 0..SIZE inclusive.
  function automatic int level_w(input int size);
    return $clog2(size) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// BITS x SIZE storage: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module fifo_mem #(
  parameter int BITS = 32,
  parameter int SIZE = 16
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [$clog2(SIZE)-1:0] waddr_i,
  input  logic [BITS-1:0]         wdata_i,
  input  logic [$clog2(SIZE)-1:0] raddr_i,
  output logic [BITS-1:0]         rdata_o
);
  logic [BITS-1:0] mem_q [SIZE];

  // Store the incoming word on an accepted write.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost flags, optional first-word-fall-
// through and sticky overflow/underflow. Pointers, level and flags live here;
// storage is in fifo_mem.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int BITS            = 32,
  parameter int SIZE            = 16,
  parameter int FWFT            = FWFT_OFF,
  parameter int ALMOST_FULL_TH  = SIZE - DEF_AF_MARGIN,
  parameter int ALMOST_EMPTY_TH = DEF_AE_TH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_flush,
  input  logic                  p_write_en,
  input  logic [BITS-1:0]       p_write_data,
  output logic                  p_write_full,
  output logic                  p_write_almost_full,
  input  logic                  p_read_en,
  output logic [BITS-1:0]       p_read_data,
  output logic                  p_read_empty,
  output logic                  p_read_almost_empty,
  output logic [$clog2(SIZE):0] p_level,
  output logic                  p_overflow,
  output logic                  p_underflow
);
  localparam int AW = $clog2(SIZE);
  localparam int LW = level_w(SIZE);

  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic [BITS-1:0] rdata_q, rdata_d, mem_rdata;
  logic            full, empty, wr_acc, rd_acc;

  // Flags come only from the registered level.
  assign full   = (level_q == LW'(SIZE));
  assign empty  = (level_q == '0);
  // Flush discards any same-cycle request.
  assign wr_acc = p_write_en & ~full  & ~p_flush;
  assign rd_acc = p_read_en  & ~empty & ~p_flush;

  fifo_mem #(.BITS(BITS), .SIZE(SIZE)) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q),
    .wdata_i (p_write_data),
    .raddr_i (rptr_q),
    .rdata_o (mem_rdata)
  );

  // Next-state for pointers, level, popped word and sticky error flags.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (p_flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) begin
        rptr_d  = rptr_q + 1'b1;
        rdata_d = mem_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (p_write_en & full);
      unf_d = unf_q | (p_read_en & empty);
    end
  end

  // State register; reset overrides flush and all requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // FWFT shows the head combinationally while non-empty; otherwise the last
  // popped word is held.
  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign p_read_data = empty ? rdata_q : mem_rdata;
    end else begin : g_reg
      assign p_read_data = rdata_q;
    end
  endgenerate

  assign p_write_full        = full;
  assign p_read_empty        = empty;
  assign p_write_almost_full = (level_q >= LW'(ALMOST_FULL_TH));
  assign p_read_almost_empty = (level_q <= LW'(ALMOST_EMPTY_TH));
  assign p_level             = level_q;
  assign p_overflow          = ovf_q;
  assign p_underflow         = unf_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench: a registered-read and an FWFT instance share one stimulus stream and
// are compared every cycle against a queue-based model of the FIFO rules.
module tb_sync_fifo_prog;
  localparam int SIZE  = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic        clk = 1'b0;
  logic        rst_n, p_flush, p_write_en, p_read_en;
  logic [31:0] p_write_data;

  logic        full0, af0, empty0, ae0, ovf0, unf0;
  logic [31:0] rdata0;
  logic [4:0]  lvl0;
  logic        full1, af1, empty1, ae1, ovf1, unf1;
  logic [31:0] rdata1;
  logic [4:0]  lvl1;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [31:0] q[$];
  bit          m_ovf, m_unf;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  sync_fifo_prog #(.BITS(32), .SIZE(SIZE), .FWFT(0),
                   .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut0 (
    .clk(clk), .rst_n(rst_n), .p_flush(p_flush),
    .p_write_en(p_write_en), .p_write_data(p_write_data),
    .p_write_full(full0), .p_write_almost_full(af0),
    .p_read_en(p_read_en), .p_read_data(rdata0),
    .p_read_empty(empty0), .p_read_almost_empty(ae0),
    .p_level(lvl0), .p_overflow(ovf0), .p_underflow(unf0));

  sync_fifo_prog #(.BITS(32), .SIZE(SIZE), .FWFT(1),
                   .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)) dut1 (
    .clk(clk), .rst_n(rst_n), .p_flush(p_flush),
    .p_write_en(p_write_en), .p_write_data(p_write_data),
    .p_write_full(full1), .p_write_almost_full(af1),
    .p_read_en(p_read_en), .p_read_data(rdata1),
    .p_read_empty(empty1), .p_read_almost_empty(ae1),
    .p_level(lvl1), .p_overflow(ovf1), .p_underflow(unf1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the rules to the model for the edge just taken.
  task automatic model_edge();
    bit full, empty, wacc, racc;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rd = '0;
    end else if (p_flush) begin
      q.delete();
    end else begin
      full  = (q.size() == SIZE);
      empty = (q.size() == 0);
      wacc  = p_write_en && !full;
      racc  = p_read_en && !empty;
      if (p_write_en && full) m_ovf = 1;
      if (p_read_en && empty) m_unf = 1;
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(p_write_data);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("level0",  32'(lvl0),  32'(n));
    chk("full0",   32'(full0), 32'(n == SIZE));
    chk("empty0",  32'(empty0), 32'(n == 0));
    chk("afull0",  32'(af0),   32'(n >= AF_TH));
    chk("aempty0", 32'(ae0),   32'(n <= AE_TH));
    chk("ovf0",    32'(ovf0),  32'(m_ovf));
    chk("unf0",    32'(unf0),  32'(m_unf));
    chk("rdata0",  rdata0,     m_rd);
    chk("level1",  32'(lvl1),  32'(n));
    chk("full1",   32'(full1), 32'(n == SIZE));
    chk("empty1",  32'(empty1), 32'(n == 0));
    chk("afull1",  32'(af1),   32'(n >= AF_TH));
    chk("aempty1", 32'(ae1),   32'(n <= AE_TH));
    chk("ovf1",    32'(ovf1),  32'(m_ovf));
    chk("unf1",    32'(unf1),  32'(m_unf));
    if (n > 0) chk("head1", rdata1, q[0]);
  endtask

  task automatic step(input logic r, input logic f, input logic w,
                      input logic [31:0] d, input logic rd);
    rst_n = r; p_flush = f; p_write_en = w; p_write_data = d; p_read_en = rd;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic wr(input logic [31:0] d); step(1, 0, 1, d, 0); endtask
  task automatic rdp();                    step(1, 0, 0, '0, 1); endtask

  initial begin
    rst_n = 0; p_flush = 0; p_write_en = 0; p_read_en = 0; p_write_data = '0;
    m_ovf = 0; m_unf = 0; m_rd = '0;

    // Reset held 3 cycles with write requested.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'hDEAD_0000 + i, 0);

    // Fill 0..F, overflow write, drain; covers every level 0..16..0.
    for (int i = 0; i < 16; i++) wr(32'(i));
    wr(32'h55);
    for (int i = 0; i < 16; i++) rdp();

    // Read while empty: underflow, held over idle cycles.
    rdp();
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0);

    // Pointer wrap: 10 in/out, then 12 words 0x100.. across the wrap.
    for (int i = 0; i < 10; i++) wr(32'h200 + i);
    for (int i = 0; i < 10; i++) rdp();
    for (int i = 0; i < 12; i++) wr(32'h100 + i);
    for (int i = 0; i < 12; i++) rdp();

    // Fresh reset, then simultaneous write+read at full and at level 5.
    step(0, 0, 0, '0, 0);
    for (int i = 0; i < 16; i++) wr(32'h300 + i);
    step(1, 0, 1, 32'hBAD, 1);
    for (int i = 0; i < 10; i++) rdp();
    step(1, 0, 1, 32'h400, 1);

    // Flush at level 7 with a same-cycle write and read.
    wr(32'h500); wr(32'h501);
    step(1, 1, 1, 32'h600, 1);
    rdp();
    wr(32'h700);
    rdp();

    // Randomized traffic: write-biased then read-biased, rare flush/reset.
    for (int i = 0; i < 400; i++) begin
      logic r, f, w, rd;
      r  = ($urandom_range(0, 59) != 0);
      f  = ($urandom_range(0, 29) == 0);
      w  = ($urandom_range(0, 3) < ((i % 100) < 50 ? 3 : 1));
      rd = ($urandom_range(0, 3) < ((i % 100) < 50 ? 1 : 3));
      step(r, f, w, $urandom, rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 SHALL have parameter BITS, default 32, width of each entry.
REQ-002 SHALL have parameter SIZE, default 16, number of entries; power of two, >=2.
REQ-003 SHALL have parameter FWFT, default 0; 0 = registered read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter ALMOST_FULL_TH, default SIZE-2, range 1..SIZE.
REQ-005 SHALL have parameter ALMOST_EMPTY_TH, default 2, range 0..SIZE-1.
REQ-006 SHALL have ports, in this order:
  clk  input  1  single clock, all logic on rising edge
  rst_n  input  1  synchronous active-low reset
  p_flush  input  1  synchronous FIFO clear
  p_write_en  input  1  write request
  p_write_data  input  BITS  write data
  p_write_full  output  1  FIFO full
  p_write_almost_full  output  1  level >= ALMOST_FULL_TH
  p_read_en  input  1  read request
  p_read_data  output  BITS  read data
  p_read_empty  output  1  FIFO empty
  p_read_almost_empty  output  1  level <= ALMOST_EMPTY_TH
  p_level  output  $clog2(SIZE)+1  current occupancy
  p_overflow  output  1  sticky: write attempted while full
  p_underflow  output  1  sticky: read attempted while empty
REQ-007 Clocking and reset SHALL be: one clock; reset is synchronous and active-low.

Function
REQ-008 Write SHALL be accepted iff p_write_en=1 and p_write_full=1 is not set in that cycle; the word is stored at the write pointer, and the pointer increments.
REQ-009 Read SHALL be accepted iff p_read_en=1 and p_read_empty=0; the read pointer increments.
REQ-010 Pointers SHALL be $clog2(SIZE) bits and wrap from SIZE-1 to 0 with no special case.
REQ-011 p_level SHALL be a registered count: +1 on a write-only cycle, -1 on a read-only cycle, unchanged when both or neither are accepted.
REQ-012 A simultaneous write and read SHALL both be accepted when the FIFO is neither full nor empty; at full, only the read is accepted; at empty, only the write is accepted.
REQ-013 p_write_full = (level==SIZE), p_read_empty = (level==0), and both almost flags SHALL derive only from the registered level; all update the cycle after the accepted operation.
REQ-014 FWFT=0: p_read_data SHALL present the popped word the cycle after an accepted read, and hold it until the next accepted read.
REQ-015 FWFT=1: p_read_data SHALL present the head entry whenever p_read_empty=0, in the same cycle empty deasserts; an accepted read advances to the next entry in the following cycle.
REQ-016 A write while full SHALL be dropped without changing state, and p_overflow SHALL be set the next cycle.
REQ-017 A read while empty SHALL be ignored, and p_underflow SHALL be set the next cycle.
REQ-018 p_overflow and p_underflow SHALL remain set until rst_n=0.
REQ-019 p_flush=1 SHALL zero both pointers and the level on the next edge.
REQ-020 p_flush SHALL take priority over any same-cycle write or read, which are discarded and do not set the sticky flags.
REQ-021 p_flush SHALL leave p_read_data and the sticky flags unchanged.

Reset
REQ-022 When rst_n=0 at a clock edge, pointers, level, p_read_data, p_overflow and p_underflow SHALL be set to 0.
REQ-023 After reset, p_read_empty=1, p_read_almost_empty=1, p_write_full=0, p_write_almost_full=0.
REQ-024 Storage contents SHALL NOT be reset.
REQ-025 Reset SHALL override flush, write and read, including when asserted mid-operation.

Structure
REQ-026 A package fifo_pkg SHALL hold the level-width function, mode constants FWFT_OFF/FWFT_ON, and the default threshold constants.
REQ-027 Storage SHALL be a sub-module fifo_mem: a BITS x SIZE memory with one synchronous write port and one read port.
REQ-028 Pointer, level and flag control SHALL reside in sync_fifo_prog.

Verification (BITS=32, SIZE=16)
REQ-029 Reset: hold rst_n=0 for 3 cycles with p_write_en=1 -> empty=1, full=0, level=0, overflow=0 and underflow=0 for the duration of reset.
REQ-030 Fill/drain, FWFT=0: write 0x0..0xF ->
  - full=1 and level=16 one cycle after the 16th write
  - a 17th write sets overflow=1
  - 16 reads return 0x0..0xF in order, each one cycle after its read
  - empty=1 afterwards
REQ-031 Wrap, FWFT=1: write 10 words, read 10, then write 12 words 0x100..0x10B ->
  - data 0x100 is visible the cycle empty deasserts
  - reads return 0x100..0x10B in order across the pointer wrap
REQ-032 Simultaneous: at level=16, assert write and read together -> read accepted, write dropped, level=15, overflow=1; at level=5, the same stimulus -> level stays 5.
REQ-033 Thresholds: with AF_TH=14 and AE_TH=2, step the level 0->16->0 -> almost_full is high exactly at levels 14..16, and almost_empty is high exactly at levels 0..2.
REQ-034 Flush/underflow:
  - flush at level=7 with a same-cycle write -> level=0 and empty=1 next cycle, write discarded
  - a read while empty -> underflow=1, held until reset
